// File: rtl/rf_pkg.sv
// Shared register-file types and constants for the write-back path.
package rf_pkg;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 32;

    typedef logic [REG_AW-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]   xdata_t;

    localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, pointer advances past the winner.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] nxt_ptr;
    logic             found;
    int               idx;

    // Scan from rr_ptr upward with wrap; first valid source wins.
    always_comb begin
        gnt     = '0;
        nxt_ptr = rr_ptr;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= int'(NUM_REQ)) begin
                idx = idx - int'(NUM_REQ);
            end
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                nxt_ptr  = (idx == int'(NUM_REQ) - 1) ? '0 : PTR_W'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= nxt_ptr;
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: round-robin grant, one-entry write stage,
// and same-cycle forwarding hits against the pending write.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned XLEN    = rf_pkg::XLEN,
    parameter int unsigned REG_AW  = rf_pkg::REG_AW
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0][REG_AW-1:0] req_rd,
    input  logic [NUM_REQ-1:0][XLEN-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           rf_we,
    output logic [REG_AW-1:0]              rf_rd,
    output logic [XLEN-1:0]                rf_data,
    input  logic [REG_AW-1:0]              rs1,
    input  logic [REG_AW-1:0]              rs2,
    output logic                           fwd1_hit,
    output logic                           fwd2_hit,
    output logic [XLEN-1:0]                fwd_data
);
    logic [NUM_REQ-1:0] gnt;
    logic               any_gnt;
    logic [REG_AW-1:0]  sel_rd;
    logic [XLEN-1:0]    sel_data;

    logic               stg_valid;
    logic [REG_AW-1:0]  stg_rd;
    logic [XLEN-1:0]    stg_data;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk (clk),
        .rst (rst),
        .req (req_valid),
        .gnt (gnt)
    );

    assign req_ready = gnt;
    assign any_gnt   = |gnt;

    // One-hot select of the granted source's payload.
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gnt[i]) begin
                sel_rd   = req_rd[i];
                sel_data = req_data[i];
            end
        end
    end

    // x0 writes still consume the grant but never raise the write enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_valid <= 1'b0;
            stg_rd    <= '0;
            stg_data  <= '0;
        end else begin
            stg_valid <= any_gnt && (sel_rd != '0);
            if (any_gnt) begin
                stg_rd   <= sel_rd;
                stg_data <= sel_data;
            end
        end
    end

    assign rf_we    = stg_valid;
    assign rf_rd    = stg_rd;
    assign rf_data  = stg_data;
    assign fwd_data = stg_data;
    assign fwd1_hit = stg_valid && (stg_rd == rs1) && (rs1 != '0);
    assign fwd2_hit = stg_valid && (stg_rd == rs2) && (rs2 != '0);
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with two sources and a shadow register file.
module tb_rf_wb_arbiter;
    logic            clk;
    logic            rst;
    logic [1:0]      req_valid;
    logic [1:0][4:0] req_rd;
    logic [1:0][31:0] req_data;
    logic [1:0]      req_ready;
    logic            rf_we;
    logic [4:0]      rf_rd;
    logic [31:0]     rf_data;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            fwd1_hit;
    logic            fwd2_hit;
    logic [31:0]     fwd_data;

    logic [31:0]     rf_model [32];
    int              n_vec;
    int              n_err;

    rf_wb_arbiter #(.NUM_REQ(2), .XLEN(32), .REG_AW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_data   (rf_data),
        .rs1       (rs1),
        .rs2       (rs2),
        .fwd1_hit  (fwd1_hit),
        .fwd2_hit  (fwd2_hit),
        .fwd_data  (fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shadow register file, committed at the end of each rf_we cycle.
    always @(posedge clk) begin
        if (rf_we) rf_model[rf_rd] <= rf_data;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int r = 0; r < 32; r++) rf_model[r] = '0;
        rst       = 1'b1;
        req_valid = '0;
        req_rd    = '0;
        req_data  = '0;
        rs1       = '0;
        rs2       = '0;

        tick();
        tick();
        check("rst_we",    64'(rf_we),    64'd0);
        check("rst_rd",    64'(rf_rd),    64'd0);
        check("rst_data",  64'(rf_data),  64'd0);
        check("rst_fwd1",  64'(fwd1_hit), 64'd0);
        check("rst_fwd2",  64'(fwd2_hit), 64'd0);
        check("rst_fwdd",  64'(fwd_data), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        rst = 1'b0;

        // Single request on source 0.
        tick();
        req_valid = 2'b01; req_rd[0] = 5'd5; req_data[0] = 32'hDEADBEEF;
        #1 check("single_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        check("single_we",   64'(rf_we),   64'd1);
        check("single_rd",   64'(rf_rd),   64'd5);
        check("single_data", 64'(rf_data), 64'hDEADBEEF);
        tick();
        check("single_we_off", 64'(rf_we), 64'd0);

        // x0 request from source 1 (pointer now 1): granted, no write.
        req_valid = 2'b10; req_rd[1] = 5'd0; req_data[1] = 32'h1234; rs1 = 5'd0;
        #1 check("x0_ready", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;
        check("x0_we",   64'(rf_we),    64'd0);
        check("x0_fwd1", 64'(fwd1_hit), 64'd0);

        // Contention, pointer back at 0: grants alternate 0,1,0,1.
        req_valid = 2'b11; req_rd[0] = 5'd3; req_rd[1] = 5'd4;
        req_data[0] = 32'h33; req_data[1] = 32'h44;
        for (int k = 0; k < 4; k++) begin
            #1 check("cont_ready", 64'(req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
            tick();
            check("cont_we", 64'(rf_we), 64'd1);
            check("cont_rd", 64'(rf_rd), (k % 2 == 0) ? 64'd3 : 64'd4);
        end
        req_valid = '0;
        tick();
        check("cont_we_off", 64'(rf_we), 64'd0);

        // Forwarding of a pending write (pointer wrapped to 0).
        req_valid = 2'b01; req_rd[0] = 5'd7; req_data[0] = 32'hA5A5A5A5;
        tick();
        req_valid = '0; rs1 = 5'd7; rs2 = 5'd8;
        #1;
        check("fwd_hit1", 64'(fwd1_hit), 64'd1);
        check("fwd_data", 64'(fwd_data), 64'hA5A5A5A5);
        check("fwd_hit2", 64'(fwd2_hit), 64'd0);
        tick();
        check("fwd_hit1_off", 64'(fwd1_hit), 64'd0);
        rs1 = '0; rs2 = '0;

        // Move pointer back to 0 via a source-1 grant.
        req_valid = 2'b10; req_rd[1] = 5'd1; req_data[1] = 32'h11;
        tick();
        req_valid = '0;
        tick();

        // Same-rd collision: 0x1 then 0x2 into x9.
        req_valid = 2'b11; req_rd[0] = 5'd9; req_rd[1] = 5'd9;
        req_data[0] = 32'h1; req_data[1] = 32'h2;
        #1 check("coll_ready0", 64'(req_ready), 64'h1);
        tick();
        req_valid = 2'b10;
        check("coll_data0", 64'(rf_data), 64'h1);
        #1 check("coll_ready1", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;
        check("coll_data1", 64'(rf_data), 64'h2);
        tick();
        tick();
        check("coll_x9", 64'(rf_model[9]), 64'h2);
        check("coll_x1", 64'(rf_model[1]), 64'h11);

        // Async reset during a write cycle; pointer left at 1 beforehand.
        req_valid = 2'b01; req_rd[0] = 5'd10; req_data[0] = 32'h55;
        tick();
        req_valid = '0;
        check("ar_we_pre", 64'(rf_we), 64'd1);
        #2 rst = 1'b1;
        #1 check("ar_we_drop", 64'(rf_we), 64'd0);
        tick();
        rst = 1'b0;
        req_valid = 2'b11; req_rd[0] = 5'd11; req_rd[1] = 5'd12;
        #1 check("ar_tie_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        check("ar_tie_rd", 64'(rf_rd), 64'd11);
        tick();
        check("ar_x10", 64'(rf_model[10]), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
